// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Shared definitions for the write-back arbiter slice.
//               XLEN   - write-back data width
//               NREG   - architectural register count
//               REG_AW - register address width
//               gnt_e  - grant encoding produced by wb_rr_arb
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

   localparam int XLEN   = 64;
   localparam int NREG   = 32;
   localparam int REG_AW = 5;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_EX   = 2'd1,
      GNT_LS   = 2'd2
   } gnt_e;

endpackage : wb_pkg
`default_nettype wire

// File: rtl/wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter_if
// Description : Bundle of the two write-back request channels (EX, LSU),
//               the register-file write port, the reservation port and the
//               pending-write bitmap.
//               modport master : pipeline side (drives requests/reservations)
//               modport slave  : arbiter side (drives ready, rf_*, busy_o)
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_arbiter_if
   import wb_pkg::*;
#(
   parameter int XLEN = wb_pkg::XLEN,
   parameter int NREG = wb_pkg::NREG
);

   // EX write-back channel
   logic              ex_valid;
   logic              ex_ready;
   logic [REG_AW-1:0] ex_waddr;
   logic [XLEN-1:0]   ex_wdata;

   // LSU write-back channel
   logic              ls_valid;
   logic              ls_ready;
   logic [REG_AW-1:0] ls_waddr;
   logic [XLEN-1:0]   ls_wdata;

   // Register-file write port
   logic              rf_we;
   logic [REG_AW-1:0] rf_waddr;
   logic [XLEN-1:0]   rf_wdata;

   // Issue-stage reservation and scoreboard
   logic              rsv_en;
   logic [REG_AW-1:0] rsv_addr;
   logic [NREG-1:0]   busy_o;

   modport master (
      output ex_valid, ex_waddr, ex_wdata,
      output ls_valid, ls_waddr, ls_wdata,
      output rsv_en, rsv_addr,
      input  ex_ready, ls_ready,
      input  rf_we, rf_waddr, rf_wdata,
      input  busy_o
   );

   modport slave (
      input  ex_valid, ex_waddr, ex_wdata,
      input  ls_valid, ls_waddr, ls_wdata,
      input  rsv_en, rsv_addr,
      output ex_ready, ls_ready,
      output rf_we, rf_waddr, rf_wdata,
      output busy_o
   );

endinterface : wb_arbiter_if
`default_nettype wire

// File: rtl/wb_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : wb_rr_arb
// Description : Two-way write-back arbiter (EX vs LSU). A lone requester is
//               granted immediately; under contention the requester that was
//               not granted most recently wins. The last-grant pointer
//               resets to EX so the LSU wins the first contention.
//               Build macro WB_ARB_FIXED_PRIO_EN: LSU always wins contention
//               and the pointer is removed.
// Ports       : clk      - clock
//               rst_n    - asynchronous active-low reset
//               ex_valid - EX request
//               ls_valid - LSU request
//               gnt      - combinational grant (GNT_NONE while in reset)
// Revision    : 1.0 - initial release
// ============================================================================
module wb_rr_arb
   import wb_pkg::*;
(
   input  wire logic clk,
   input  wire logic rst_n,
   input  wire logic ex_valid,
   input  wire logic ls_valid,
   output gnt_e      gnt
);

`ifdef WB_ARB_FIXED_PRIO_EN

   always_comb begin
      gnt = GNT_NONE;
      if (rst_n) begin
         if (ls_valid) begin
            gnt = GNT_LS;
         end else if (ex_valid) begin
            gnt = GNT_EX;
         end
      end
   end

`else

   // 1: LSU was granted most recently, 0: EX was.
   logic r_last_ls;

   always_comb begin
      gnt = GNT_NONE;
      if (rst_n) begin
         if (ex_valid && ls_valid) begin
            gnt = r_last_ls ? GNT_EX : GNT_LS;
         end else if (ls_valid) begin
            gnt = GNT_LS;
         end else if (ex_valid) begin
            gnt = GNT_EX;
         end
      end
   end

   // Pointer follows every grant, contended or not.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last_ls <= 1'b0;
      end else if (gnt == GNT_LS) begin
         r_last_ls <= 1'b1;
      end else if (gnt == GNT_EX) begin
         r_last_ls <= 1'b0;
      end
   end

`endif

endmodule : wb_rr_arb
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter
// Description : Write-back arbiter merging the EX and LSU result channels
//               onto a single register-file write port, plus a per-register
//               pending-write scoreboard.
//               - ready is combinational from valid and the arbiter grant
//               - the write port is registered: grant in cycle N appears on
//                 rf_we/rf_waddr/rf_wdata in cycle N+1 for one cycle
//               - writes to x0 are accepted but never issued
//               - busy_o bit set by a reservation, cleared by the write;
//                 set wins over clear on the same register
//               Build macro WB_ARB_FIXED_PRIO_EN selects fixed LSU priority
//               instead of round-robin (handled in wb_rr_arb).
// Ports       : clk   - clock
//               rst_n - asynchronous active-low reset
//               bus   - wb_arbiter_if.slave (request channels, write port,
//                       reservation port, busy_o bitmap)
// Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter
   import wb_pkg::*;
#(
   parameter int XLEN = wb_pkg::XLEN,
   parameter int NREG = wb_pkg::NREG
)
(
   input  wire logic     clk,
   input  wire logic     rst_n,
   wb_arbiter_if.slave   bus
);

   gnt_e              w_gnt;
   logic [REG_AW-1:0] w_sel_addr;
   logic [XLEN-1:0]   w_sel_data;
   logic              w_wr;

   logic              r_rf_we;
   logic [REG_AW-1:0] r_rf_waddr;
   logic [XLEN-1:0]   r_rf_wdata;

   logic [NREG-1:0]   w_set;
   logic [NREG-1:0]   w_clr;
   logic [NREG-1:0]   r_busy;

   // ------------------------------------------------------------------
   // Arbitration
   // ------------------------------------------------------------------
   wb_rr_arb u_arb (
      .clk      (clk),
      .rst_n    (rst_n),
      .ex_valid (bus.ex_valid),
      .ls_valid (bus.ls_valid),
      .gnt      (w_gnt)
   );

   // The arbiter already returns GNT_NONE during reset and never grants a
   // channel without its valid, so ready follows directly from the grant.
   assign bus.ex_ready = (w_gnt == GNT_EX);
   assign bus.ls_ready = (w_gnt == GNT_LS);

   always_comb begin
      w_sel_addr = '0;
      w_sel_data = '0;
      case (w_gnt)
         GNT_EX: begin
            w_sel_addr = bus.ex_waddr;
            w_sel_data = bus.ex_wdata;
         end
         GNT_LS: begin
            w_sel_addr = bus.ls_waddr;
            w_sel_data = bus.ls_wdata;
         end
         default: begin
            w_sel_addr = '0;
            w_sel_data = '0;
         end
      endcase
   end

   // A grant to x0 is consumed without producing a write.
   assign w_wr = (w_gnt != GNT_NONE) && (w_sel_addr != '0);

   // ------------------------------------------------------------------
   // Registered write port; address/data hold while rf_we is low.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rf_we    <= 1'b0;
         r_rf_waddr <= '0;
         r_rf_wdata <= '0;
      end else begin
         r_rf_we <= w_wr;
         if (w_wr) begin
            r_rf_waddr <= w_sel_addr;
            r_rf_wdata <= w_sel_data;
         end
      end
   end

   assign bus.rf_we    = r_rf_we;
   assign bus.rf_waddr = r_rf_waddr;
   assign bus.rf_wdata = r_rf_wdata;

   // ------------------------------------------------------------------
   // Scoreboard. Per-bit decode keeps the indexing in range for any NREG;
   // bit 0 has no set/clear term so it stays at its reset value of 0.
   // ------------------------------------------------------------------
   for (genvar i = 0; i < NREG; i++) begin : g_busy
      if (i == 0) begin : g_zero
         assign w_set[i] = 1'b0;
         assign w_clr[i] = 1'b0;
      end else begin : g_reg
         localparam logic [REG_AW-1:0] c_idx = REG_AW'(i);
         assign w_set[i] = bus.rsv_en && (bus.rsv_addr == c_idx);
         assign w_clr[i] = r_rf_we    && (r_rf_waddr   == c_idx);
      end
   end

   // Clear applied first, then set, so a same-cycle set wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy <= '0;
      end else begin
         r_busy <= (r_busy & ~w_clr) | w_set;
      end
   end

   assign bus.busy_o = r_busy;

endmodule : wb_arbiter
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_arbiter
// Description : Self-checking bench for wb_arbiter. Directed scenarios for
//               single grants, contention order, x0 writes, scoreboard
//               set/clear and mid-cycle reset, followed by randomized
//               traffic compared against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;
   import wb_pkg::*;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   wb_arbiter_if bus ();

   wb_arbiter dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state: expected registered outputs and last winner.
   logic            m_we;
   logic [4:0]      m_waddr;
   logic [63:0]     m_wdata;
   logic [31:0]     m_busy;
   int              m_last;   // 1 = EX granted last, 2 = LSU granted last
   int              m_g;      // grant expected in the most recent cycle

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_we    = 1'b0;
      m_waddr = '0;
      m_wdata = '0;
      m_busy  = '0;
      m_last  = 1;
      m_g     = 0;
   endtask

   // 0 none, 1 EX, 2 LSU
   function automatic int exp_grant();
      if (!rst_n) return 0;
      if (bus.ex_valid && !bus.ls_valid) return 1;
      if (bus.ls_valid && !bus.ex_valid) return 2;
      if (bus.ex_valid && bus.ls_valid) begin
`ifdef WB_ARB_FIXED_PRIO_EN
         return 2;
`else
         return (m_last == 2) ? 1 : 2;
`endif
      end
      return 0;
   endfunction

   task automatic model_update(input int g);
      logic [31:0] nb;
      logic [4:0]  a;
      logic [63:0] d;
      nb = m_busy;
      if (m_we) nb[m_waddr] = 1'b0;
      if (bus.rsv_en && bus.rsv_addr != 0) nb[bus.rsv_addr] = 1'b1;
      m_busy = nb;
      if (g != 0) begin
         a = (g == 1) ? bus.ex_waddr : bus.ls_waddr;
         d = (g == 1) ? bus.ex_wdata : bus.ls_wdata;
         m_last = g;
         if (a != 0) begin
            m_we    = 1'b1;
            m_waddr = a;
            m_wdata = d;
         end else begin
            m_we = 1'b0;
         end
      end else begin
         m_we = 1'b0;
      end
   endtask

   task automatic check_outputs(input int g);
      chk("ex_ready", bus.ex_ready, (g == 1));
      chk("ls_ready", bus.ls_ready, (g == 2));
      chk("rf_we",    bus.rf_we,    m_we);
      chk("rf_waddr", bus.rf_waddr, m_waddr);
      chk("rf_wdata", bus.rf_wdata, m_wdata);
      chk("busy_o",   bus.busy_o,   m_busy);
   endtask

   // One clock: compare mid-cycle, advance the model at the edge, return
   // just after the edge so the caller can drive the next inputs.
   task automatic cycle();
      @(negedge clk);
      m_g = exp_grant();
      check_outputs(m_g);
      @(posedge clk);
      model_update(m_g);
      #1;
   endtask

   task automatic gen_random();
      if (!(bus.ex_valid && m_g != 1)) begin
         bus.ex_valid = ($urandom_range(0, 99) < 60);
         bus.ex_waddr = 5'($urandom_range(0, 31));
         bus.ex_wdata = {$urandom, $urandom};
      end
      if (!(bus.ls_valid && m_g != 2)) begin
         bus.ls_valid = ($urandom_range(0, 99) < 60);
         bus.ls_waddr = 5'($urandom_range(0, 31));
         bus.ls_wdata = {$urandom, $urandom};
      end
      bus.rsv_en   = ($urandom_range(0, 99) < 30);
      bus.rsv_addr = 5'($urandom_range(0, 31));
   endtask

   int          exp_seq [4];
   logic [4:0]  got_seq [4];

   initial begin
      bus.ex_valid = 1'b0; bus.ex_waddr = '0; bus.ex_wdata = '0;
      bus.ls_valid = 1'b0; bus.ls_waddr = '0; bus.ls_wdata = '0;
      bus.rsv_en   = 1'b0; bus.rsv_addr = '0;
      rst_n = 1'b1;
      model_reset();
      #1 rst_n = 1'b0;
      bus.ex_valid = 1'b1;

      // Reset state, including no ready while held in reset
      @(negedge clk);
      chk("rst_ex_ready", bus.ex_ready, 1'b0);
      chk("rst_rf_we",    bus.rf_we,    1'b0);
      chk("rst_rf_waddr", bus.rf_waddr, 5'd0);
      chk("rst_rf_wdata", bus.rf_wdata, 64'd0);
      chk("rst_busy",     bus.busy_o,   32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      bus.ex_valid = 1'b0;

      // Single EX write: ready same cycle, write next cycle only
      bus.ex_valid = 1'b1; bus.ex_waddr = 5'd5; bus.ex_wdata = 64'hAA;
      #1 chk("t_ex_ready", bus.ex_ready, 1'b1);
      cycle();
      bus.ex_valid = 1'b0;
      chk("t_ex_we",    bus.rf_we,    1'b1);
      chk("t_ex_waddr", bus.rf_waddr, 5'd5);
      chk("t_ex_wdata", bus.rf_wdata, 64'hAA);
      cycle();
      chk("t_ex_we_drop", bus.rf_we, 1'b0);

      // Contention for four cycles
`ifdef WB_ARB_FIXED_PRIO_EN
      exp_seq = '{2, 2, 2, 2};
`else
      exp_seq = '{2, 1, 2, 1};
`endif
      bus.ex_valid = 1'b1; bus.ex_waddr = 5'd1; bus.ex_wdata = 64'h11;
      bus.ls_valid = 1'b1; bus.ls_waddr = 5'd2; bus.ls_wdata = 64'h22;
      for (int k = 0; k < 4; k++) begin
         cycle();
         got_seq[k] = bus.rf_waddr;
      end
      bus.ex_valid = 1'b0; bus.ls_valid = 1'b0;
      for (int k = 0; k < 4; k++) chk("t_cont_seq", 64'(got_seq[k]), 64'(exp_seq[k]));

      // LSU write to x0: accepted, no write, busy untouched
      bus.ls_valid = 1'b1; bus.ls_waddr = 5'd0; bus.ls_wdata = 64'h33;
      #1 chk("t_x0_ready", bus.ls_ready, 1'b1);
      cycle();
      bus.ls_valid = 1'b0;
      chk("t_x0_we",   bus.rf_we,  1'b0);
      chk("t_x0_busy", bus.busy_o, 32'd0);
      cycle();

      // Reservation of x7, then write to x7 clears it
      bus.rsv_en = 1'b1; bus.rsv_addr = 5'd7;
      cycle();
      bus.rsv_en = 1'b0;
      chk("t_rsv_set", bus.busy_o[7], 1'b1);
      bus.ex_valid = 1'b1; bus.ex_waddr = 5'd7; bus.ex_wdata = 64'h77;
      cycle();
      bus.ex_valid = 1'b0;
      chk("t_rsv_hold", bus.busy_o[7], 1'b1);
      cycle();
      chk("t_rsv_clr", bus.busy_o[7], 1'b0);

      // Same-cycle set and clear of x7: set wins
      bus.rsv_en = 1'b1; bus.rsv_addr = 5'd7;
      cycle();
      bus.rsv_en = 1'b0;
      bus.ex_valid = 1'b1; bus.ex_waddr = 5'd7; bus.ex_wdata = 64'h78;
      cycle();
      bus.ex_valid = 1'b0;
      bus.rsv_en = 1'b1; bus.rsv_addr = 5'd7;
      cycle();
      bus.rsv_en = 1'b0;
      chk("t_set_wins", bus.busy_o[7], 1'b1);
      cycle();

      // Mid-cycle reset after an LSU grant
      bus.ls_valid = 1'b1; bus.ls_waddr = 5'd4; bus.ls_wdata = 64'h44;
      bus.rsv_en = 1'b1; bus.rsv_addr = 5'd4;
      cycle();
      bus.rsv_en = 1'b0;
      #3 rst_n = 1'b0;
      model_reset();
      #1;
      chk("t_rst_we",       bus.rf_we,    1'b0);
      chk("t_rst_busy",     bus.busy_o,   32'd0);
      chk("t_rst_ls_ready", bus.ls_ready, 1'b0);
      chk("t_rst_waddr",    bus.rf_waddr, 5'd0);
      @(posedge clk);
      #1;
      chk("t_rst_we_edge", bus.rf_we, 1'b0);
      rst_n = 1'b1;
      bus.ls_valid = 1'b0;
      cycle();
      chk("t_rst_no_write", bus.rf_we, 1'b0);
      bus.ex_valid = 1'b1; bus.ex_waddr = 5'd10; bus.ex_wdata = 64'hA0;
      bus.ls_valid = 1'b1; bus.ls_waddr = 5'd11; bus.ls_wdata = 64'hB0;
      #1;
      chk("t_rst_cont_ls", bus.ls_ready, 1'b1);
      chk("t_rst_cont_ex", bus.ex_ready, 1'b0);
      cycle();
      bus.ex_valid = 1'b0; bus.ls_valid = 1'b0;
      chk("t_rst_cont_addr", bus.rf_waddr, 5'd11);

      // Randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         gen_random();
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_wb_arbiter
`default_nettype wire

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter: XLEN, default 64, width of write-back data.
REQ-002 Parameter: NREG, default 32, architectural register count; address width is log2(NREG) = 5.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 ex_valid  input  1  ALU/EX write-back request.
REQ-006 ex_ready  output  1  EX request accepted this cycle.
REQ-007 ex_waddr / ex_wdata  input  5 / XLEN  EX destination and data.
REQ-008 ls_valid  input  1  load/LSU write-back request.
REQ-009 ls_ready  output  1  LSU request accepted this cycle.
REQ-010 ls_waddr / ls_wdata  input  5 / XLEN  LSU destination and data.
REQ-011 rf_we / rf_waddr / rf_wdata  output  1 / 5 / XLEN  single register-file write port.
REQ-012 rsv_en / rsv_addr  input  1 / 5  issue stage reserves a destination register.
REQ-013 busy_o  output  NREG  per-register pending-write bitmap.

Function
REQ-014 Handshake: a transfer occurs when valid and ready are both high; ready is combinational from valid and arbitration state; a requester holds valid, waddr and wdata stable until accepted.
REQ-015 At most one of ex_ready/ls_ready is high per cycle; ready is never high without the matching valid.
REQ-016 Single requester valid: that requester is granted the same cycle.
REQ-017 Both valid (round-robin mode): grant the requester not granted most recently; last-grant pointer resets to EX, so LSU wins the first contention.
REQ-018 Last-grant pointer updates on every grant, contended or not; a requester waits at most one cycle under continuous contention.
REQ-019 Output stage registered: grant in cycle N -> rf_we/rf_waddr/rf_wdata valid in cycle N+1 for exactly one cycle; no grant in N -> rf_we=0 in N+1.
REQ-020 Granted waddr==0: request is accepted (ready high), rf_we stays 0, and busy_o is unchanged.
REQ-021 rf_waddr/rf_wdata hold their last values when rf_we=0.
REQ-022 Scoreboard: rsv_en with rsv_addr!=0 sets busy_o[rsv_addr] on the next edge; rsv_addr==0 is ignored.
REQ-023 Scoreboard: rf_we=1 clears busy_o[rf_waddr] on the next edge.
REQ-024 Simultaneous set and clear of the same register: set wins, so busy stays 1.
REQ-025 busy_o[0] is constant 0.
REQ-026 No internal queue: back-to-back grants sustain one write per cycle with no bubbles.

Reset
REQ-027 rst_n low asynchronously forces rf_we=0, rf_waddr=0, rf_wdata=0, busy_o=0 and the last-grant pointer to EX.
REQ-028 ex_ready/ls_ready are 0 while rst_n is low.
REQ-029 A grant registered before reset is discarded; no write is issued after reset deasserts.
REQ-030 Reset deassertion is synchronous to clk (synchronized upstream); the first grant is possible in the first cycle after deassertion.

Configuration
REQ-031 Macro WB_ARB_FIXED_PRIO_EN.
REQ-032 Defined: LSU always wins contention; the pointer logic is removed; EX can starve while ls_valid stays high.
REQ-033 Undefined: round-robin per REQ-017/018.

Structure
REQ-034 Shared package wb_pkg holds XLEN, NREG, REG_AW=5 and the grant enum {GNT_NONE, GNT_EX, GNT_LS}.
REQ-035 One sub-module, wb_rr_arb: 2-way arbiter with pointer (or fixed priority under the macro) that outputs the grant enum.
REQ-036 The scoreboard and output register live in wb_arbiter.

Verification
REQ-037 Reset, then ex_valid=1, ex_waddr=5, ex_wdata=0xAA -> ex_ready=1 same cycle; rf_we=1, rf_waddr=5, rf_wdata=0xAA next cycle only.
REQ-038 Both valid for 4 cycles with constant payloads (EX x1, LSU x2) -> grants LS, EX, LS, EX; rf_waddr sequence 2,1,2,1 one cycle delayed; with WB_ARB_FIXED_PRIO_EN the sequence is 2,2,2,2.
REQ-039 ls_valid=1, ls_waddr=0 -> ls_ready=1, rf_we stays 0, busy_o stays 0.
REQ-040 rsv_en with rsv_addr=7, then an EX write to 7 -> busy_o[7] is 1 from the edge after rsv_en until the edge after rf_we; rsv_en to 7 in the same cycle as rf_we to 7 -> busy_o[7] stays 1.
REQ-041 rst_n asserted mid-cycle after a grant and before the edge -> rf_we=0 immediately, busy_o=0, no write after release; the next contention goes to LSU.
